// File: rtl/serial_word_rx_if.sv
// serial_word_rx_if: received-word valid/ready channel
interface serial_word_rx_if #(parameter int WIDTH = 8);
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/serial_word_rx.sv
// serial_word_rx: inverted single-wire serial receiver, LSB-first frames to valid/ready words
// Optional even-parity bit after the data bits when SERIAL_WORD_RX_PARITY_EN is defined.
module serial_word_rx #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_n,
   serial_word_rx_if.master word,
   output logic             overrun,
   output logic             par_err
);
   localparam int CW = $clog2(WIDTH + 1);
`ifdef SERIAL_WORD_RX_PARITY_EN
   typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
`else
   typedef enum logic {IDLE, DATA} state_t;
`endif
   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;
   logic             done, load;
   logic             b;
`ifdef SERIAL_WORD_RX_PARITY_EN
   logic             bad;
   logic             perr_q;
`endif
   assign b = ~rx_n;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      done    = 1'b0;
`ifdef SERIAL_WORD_RX_PARITY_EN
      bad     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            state_d = b ? DATA : IDLE;
            cnt_d   = '0;
         end
         DATA: begin
            // right shift so the first (LSB) bit lands in bit 0 after WIDTH bits
            shift_d = WIDTH'({b, shift_q} >> 1);
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SERIAL_WORD_RX_PARITY_EN
               state_d = PARITY;
`else
               state_d = IDLE;
               done    = 1'b1;
`endif
            end
         end
`ifdef SERIAL_WORD_RX_PARITY_EN
         PARITY: begin
            state_d = IDLE;
            bad     = ^{shift_q, b};
            done    = ~bad;
         end
`endif
         default: state_d = IDLE;
      endcase
   end
   // a completed word is taken only if the output slot is free or emptying this cycle
   assign load    = done & (~valid_q | word.out_ready);
   assign data_d  = load ? shift_d : data_q;
   assign valid_d = load | (valid_q & ~word.out_ready);
   assign ovr_d   = ovr_q | (done & valid_q & ~word.out_ready);
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end
`ifdef SERIAL_WORD_RX_PARITY_EN
   always_ff @(posedge clk) perr_q <= rst ? 1'b0 : bad;
   assign par_err = perr_q;
`else
   assign par_err = 1'b0;
`endif
   assign word.out_data  = data_q;
   assign word.out_valid = valid_q;
   assign overrun        = ovr_q;
endmodule

// File: tb/tb_serial_word_rx.sv
// tb_serial_word_rx: frame vectors, corner sequences and random traffic against a frame-level model
module tb_serial_word_rx;
   localparam int WIDTH = 8;
`ifdef SERIAL_WORD_RX_PARITY_EN
   localparam int FL = WIDTH + 1;
`else
   localparam int FL = WIDTH;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx_n = 1'b1;
   logic overrun, par_err;
   serial_word_rx_if #(.WIDTH(WIDTH)) wif();
   serial_word_rx #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .rx_n(rx_n), .word(wif.master),
      .overrun(overrun), .par_err(par_err)
   );
   always #5 clk = ~clk;
   int n_chk = 0;
   int n_fail = 0;
   bit m_in = 0;
   bit q[$];
   logic [WIDTH-1:0] m_data = '0;
   bit m_valid = 0, m_ovr = 0, m_perr = 0;
   typedef struct {
      logic [WIDTH-1:0] word;
      logic [WIDTH-1:0] exp_data;
   } vec_t;
   vec_t vecs[6];
   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   function automatic void model_step(bit r, bit b, bit rdy);
      bit done = 0, ok = 1;
      int ones = 0;
      logic [WIDTH-1:0] w = '0;
      if (r) begin
         m_in = 0; q.delete(); m_data = '0; m_valid = 0; m_ovr = 0; m_perr = 0;
         return;
      end
      if (!m_in) m_in = b;
      else begin
         q.push_back(b);
         if (q.size() == FL) begin
            done = 1;
            m_in = 0;
            foreach (q[i]) ones += int'(q[i]);
            for (int i = 0; i < WIDTH; i++) w = w | (WIDTH'(q[i]) << i);
            ok = (FL == WIDTH) || (ones % 2 == 0);
            q.delete();
         end
      end
      m_perr = done && !ok;
      if (done && ok) begin
         if (!m_valid || rdy) begin m_data = w; m_valid = 1; end
         else m_ovr = 1;
      end else if (m_valid && rdy) m_valid = 0;
   endfunction
   task automatic cyc(bit b, bit rdy);
      rx_n = ~b;
      wif.out_ready = rdy;
      @(posedge clk);
      model_step(rst, b, rdy);
      #1;
      check("data", wif.out_data, m_data);
      check("valid", wif.out_valid, m_valid);
      check("overrun", overrun, m_ovr);
      check("par_err", par_err, m_perr);
   endtask
   task automatic rst_cycles(int n);
      rst = 1'b1;
      repeat (n) cyc(0, 0);
      rst = 1'b0;
   endtask
   task automatic send(logic [WIDTH-1:0] w, bit rdy, bit flip_par);
      cyc(1, rdy);
      for (int i = 0; i < WIDTH; i++) cyc(w[i], rdy);
`ifdef SERIAL_WORD_RX_PARITY_EN
      cyc((^w) ^ flip_par, rdy);
`else
      if (flip_par) $display("note: parity flip ignored without parity");
`endif
   endtask
   initial begin
      logic [WIDTH-1:0] ff = '1;
      logic [WIDTH-1:0] a5 = 8'hA5;
      vecs[0] = '{8'hA5, 8'hA5};
      vecs[1] = '{8'h00, 8'h00};
      vecs[2] = '{8'hFF, 8'hFF};
      vecs[3] = '{8'h01, 8'h01};
      vecs[4] = '{8'h80, 8'h80};
      vecs[5] = '{8'h5A, 8'h5A};
      wif.out_ready = 1'b0;
      rst_cycles(2);
      check("rst_valid", wif.out_valid, 0);
      check("rst_data", wif.out_data, 0);
      check("rst_ovr", overrun, 0);
      // reset mid-frame aborts it
      cyc(1, 0); cyc(1, 0); cyc(1, 0);
      rst_cycles(2);
      check("midrst_valid", wif.out_valid, 0);
      check("midrst_data", wif.out_data, 0);
      send(8'h3C, 0, 0);
      check("after_rst_data", wif.out_data, 8'h3C);
      check("after_rst_valid", wif.out_valid, 1);
      foreach (vecs[k]) begin
         rst_cycles(1);
         send(vecs[k].word, 1, 0);
         check("vec_data", wif.out_data, vecs[k].exp_data);
         check("vec_valid", wif.out_valid, 1);
         check("vec_ovr", overrun, 0);
         cyc(0, 1);
         check("vec_clear", wif.out_valid, 0);
      end
      // latency of 0xA5
      rst_cycles(1);
      cyc(1, 1);
      for (int i = 0; i < WIDTH - 1; i++) cyc(a5[i], 1);
      check("lat_early", wif.out_valid, 0);
      cyc(a5[WIDTH-1], 1);
`ifdef SERIAL_WORD_RX_PARITY_EN
      check("lat_par_early", wif.out_valid, 0);
      cyc(^a5, 1);
`endif
      check("lat_valid", wif.out_valid, 1);
      check("lat_data", wif.out_data, 8'hA5);
      cyc(0, 1);
      check("lat_one_cycle", wif.out_valid, 0);
      // back-to-back with consumer stalled
      rst_cycles(1);
      send(8'h3C, 0, 0);
      send(8'hC3, 0, 0);
      check("b2b_data", wif.out_data, 8'h3C);
      check("b2b_valid", wif.out_valid, 1);
      check("b2b_ovr", overrun, 1);
      cyc(0, 1);
      check("b2b_clear", wif.out_valid, 0);
      check("b2b_ovr_sticky", overrun, 1);
      // pending word accepted on the completion cycle of the next
      rst_cycles(1);
      send(8'h01, 0, 0);
      cyc(1, 0);
      for (int i = 0; i < FL; i++) cyc(i < WIDTH ? ff[i] : ^ff, i == FL - 1);
      check("swap_data", wif.out_data, 8'hFF);
      check("swap_valid", wif.out_valid, 1);
      check("swap_ovr", overrun, 0);
      // idle line
      rst_cycles(1);
      repeat (20) cyc(0, 0);
      check("idle_valid", wif.out_valid, 0);
      send(8'h5A, 0, 0);
      check("idle_then_data", wif.out_data, 8'h5A);
`ifdef SERIAL_WORD_RX_PARITY_EN
      rst_cycles(1);
      send(8'h07, 0, 0);
      check("par_ok_data", wif.out_data, 8'h07);
      cyc(0, 1);
      send(8'h07, 0, 1);
      check("par_err_pulse", par_err, 1);
      check("par_err_valid", wif.out_valid, 0);
      cyc(0, 0);
      check("par_err_clear", par_err, 0);
`endif
      // random traffic with occasional resets
      rst_cycles(1);
      for (int n = 0; n < 4000; n++) begin
         rst = ($urandom_range(0, 299) == 0);
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      end
      rst = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
